ddr_ctr_rd_resp: RTL and testbench



---
 rtl/ddr_ctr_rd_resp.sv | 151 +++++++++++++++
 tb/tb_ddr_ctr_rd_resp.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ddr_ctr_rd_resp.sv
// Read-channel responder that stands in for a DDR controller. It returns address-derived
// data for one INCR burst at a time and waits for R-channel backpressure.
module ddr_ctr_rd_resp #(
    parameter int unsigned INIT_CYCLES = 32'd16,
    parameter int unsigned LATENCY     = 32'd4,
    parameter logic [31:0] PATTERN     = 32'hA5A50000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    output logic        ddr_ready
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    state_t      state_r,     state_s;
    logic [31:0] init_cnt_r,  init_cnt_s;
    logic [31:0] wait_cnt_r,  wait_cnt_s;
    logic [31:0] cur_addr_r,  cur_addr_s;
    logic [7:0]  len_r,       len_s;
    logic [8:0]  beat_r,      beat_s;
    logic        arready_r,   arready_s;
    logic        rvalid_r,    rvalid_s;
    logic        rlast_r,     rlast_s;
    logic [31:0] rdata_r,     rdata_s;
    logic        ddr_ready_r, ddr_ready_s;
    logic [31:0] addr_inc_s;

    // Low address bits ride along unchanged and the sum wraps at 2^32.
    assign addr_inc_s = cur_addr_r + 32'd4;

    // Next-state and next-output computation.
    always_comb begin
        state_s     = state_r;
        init_cnt_s  = init_cnt_r;
        wait_cnt_s  = wait_cnt_r;
        cur_addr_s  = cur_addr_r;
        len_s       = len_r;
        beat_s      = beat_r;
        arready_s   = arready_r;
        rvalid_s    = rvalid_r;
        rlast_s     = rlast_r;
        rdata_s     = rdata_r;
        ddr_ready_s = ddr_ready_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == (INIT_CYCLES - 32'd1)) begin
                    ddr_ready_s = 1'b1;
                    arready_s   = 1'b1;
                    init_cnt_s  = 32'd0;
                    state_s     = ST_IDLE;
                end else begin
                    init_cnt_s = init_cnt_r + 32'd1;
                end
            end
            ST_IDLE: begin
                if (arvalid && arready_r) begin
                    cur_addr_s = araddr;
                    len_s      = arlen;
                    beat_s     = 9'd0;
                    arready_s  = 1'b0;
                    wait_cnt_s = LATENCY - 32'd1;
                    state_s    = ST_WAIT;
                end else begin
                    arready_s = 1'b1;
                end
            end
            ST_WAIT: begin
                // A zero count here means this edge is LATENCY edges past the handshake.
                if (wait_cnt_r == 32'd0) begin
                    rvalid_s = 1'b1;
                    rdata_s  = cur_addr_r ^ PATTERN;
                    rlast_s  = (len_r == 8'd0);
                    state_s  = ST_BURST;
                end else begin
                    wait_cnt_s = wait_cnt_r - 32'd1;
                end
            end
            ST_BURST: begin
                if (rvalid_r && rready) begin
                    if (rlast_r) begin
                        rvalid_s  = 1'b0;
                        rlast_s   = 1'b0;
                        arready_s = 1'b1;
                        state_s   = ST_IDLE;
                    end else begin
                        cur_addr_s = addr_inc_s;
                        beat_s     = beat_r + 9'd1;
                        rdata_s    = addr_inc_s ^ PATTERN;
                        rlast_s    = ((beat_r + 9'd1) == {1'b0, len_r});
                    end
                end else begin
                    state_s = ST_BURST;
                end
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= 32'd0;
            wait_cnt_r  <= 32'd0;
            cur_addr_r  <= 32'd0;
            len_r       <= 8'd0;
            beat_r      <= 9'd0;
            arready_r   <= 1'b0;
            rvalid_r    <= 1'b0;
            rlast_r     <= 1'b0;
            rdata_r     <= 32'd0;
            ddr_ready_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            init_cnt_r  <= init_cnt_s;
            wait_cnt_r  <= wait_cnt_s;
            cur_addr_r  <= cur_addr_s;
            len_r       <= len_s;
            beat_r      <= beat_s;
            arready_r   <= arready_s;
            rvalid_r    <= rvalid_s;
            rlast_r     <= rlast_s;
            rdata_r     <= rdata_s;
            ddr_ready_r <= ddr_ready_s;
        end
    end

    assign arready   = arready_r;
    assign rvalid    = rvalid_r;
    assign rlast     = rlast_r;
    assign rdata     = rdata_r;
    assign ddr_ready = ddr_ready_r;
    assign rresp     = 2'b00;

endmodule

// File: tb/tb_ddr_ctr_rd_resp.sv
// Self-checking bench for ddr_ctr_rd_resp. Each beat is predicted as
// (start + 4*i) ^ PATTERN, and rlast as i == arlen.
module tb_ddr_ctr_rd_resp;

    localparam int unsigned INIT_CYCLES = 16;
    localparam int unsigned LATENCY     = 4;
    localparam logic [31:0] PATTERN     = 32'hA5A50000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] araddr = 32'd0;
    logic [7:0]  arlen = 8'd0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        ddr_ready;

    int total  = 0;
    int passed = 0;

    ddr_ctr_rd_resp #(
        .INIT_CYCLES(INIT_CYCLES),
        .LATENCY(LATENCY),
        .PATTERN(PATTERN)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .araddr(araddr),
        .arlen(arlen),
        .arvalid(arvalid),
        .arready(arready),
        .rdata(rdata),
        .rresp(rresp),
        .rlast(rlast),
        .rvalid(rvalid),
        .rready(rready),
        .ddr_ready(ddr_ready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset values, then the init delay while arvalid is held high.
    task automatic test_reset;
        int n;
        rstn = 1'b0; arvalid = 1'b1; araddr = 32'h40; arlen = 8'd0; rready = 1'b0;
        repeat (3) tick;
        total++;
        if ({ddr_ready, arready, rvalid, rlast, rdata, rresp} !== 37'd0)
            $display("FAIL reset_values got rdy=%b arr=%b rv=%b rl=%b rd=%h rr=%b required all 0",
                     ddr_ready, arready, rvalid, rlast, rdata, rresp);
        else passed++;
        rstn = 1'b1;
        n = 0;
        while (ddr_ready !== 1'b1 && n < 100) begin
            total++;
            if (arready !== 1'b0) $display("FAIL init_arready cycle %0d got %b required 0", n, arready);
            else passed++;
            tick;
            n++;
        end
        total++;
        if (n != INIT_CYCLES) $display("FAIL init_delay got %0d cycles required %0d", n, INIT_CYCLES);
        else passed++;
        total++;
        if (arready !== 1'b1) $display("FAIL init_arready_up got %b required 1", arready);
        else passed++;
        arvalid = 1'b0;
    endtask

    // Issues one AR request and checks every returned beat against the model.
    // mode: 0 = rready always high, 1 = random rready, 2 = rready pattern 1,0,0,1.
    // abort_at >= 0 drops rstn while that beat is being presented.
    task automatic run_burst(input string name, input logic [31:0] addr, input int len,
                             input int mode, input int abort_at);
        int n, lat, i, k;
        logic [31:0] exp_data;
        logic r;
        araddr = addr; arlen = len[7:0]; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (arready !== 1'b1 && n < 200) begin tick; n++; end
        total++;
        if (n >= 200) begin
            $display("FAIL %s ar_timeout got arready=%b required 1", name, arready);
            arvalid = 1'b0;
            return;
        end else passed++;
        tick;
        arvalid = 1'b0; araddr = $urandom; arlen = 8'($urandom);
        total++;
        if (arready !== 1'b0) $display("FAIL %s arready_drop got %b required 0", name, arready);
        else passed++;
        lat = 0;
        while (rvalid !== 1'b1 && lat < 200) begin tick; lat++; end
        total++;
        if (lat != LATENCY) $display("FAIL %s latency got %0d edges required %0d", name, lat, LATENCY);
        else passed++;
        if (lat >= 200) return;
        i = 0; k = 0;
        while (i <= len && k < 2000) begin
            exp_data = (addr + (32'(i) << 2)) ^ PATTERN;
            total++;
            if ({rvalid, arready, rresp} !== 4'b1000) begin
                $display("FAIL %s beat%0d_ctrl got rv=%b arr=%b rr=%b required 1,0,00",
                         name, i, rvalid, arready, rresp);
                break;
            end else passed++;
            total++;
            if (rdata !== exp_data) $display("FAIL %s beat%0d_rdata got %h required %h", name, i, rdata, exp_data);
            else passed++;
            total++;
            if (rlast !== (i == len)) $display("FAIL %s beat%0d_rlast got %b required %b", name, i, rlast, (i == len));
            else passed++;
            if (i == abort_at) begin
                rstn = 1'b0;
                tick;
                total++;
                if ({rvalid, rlast, arready, ddr_ready, rdata} !== 36'd0)
                    $display("FAIL %s mid_reset got rv=%b rl=%b arr=%b rdy=%b rd=%h required all 0",
                             name, rvalid, rlast, arready, ddr_ready, rdata);
                else passed++;
                rready = 1'b0;
                return;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = ((k % 4) == 0) || ((k % 4) == 3);
            endcase
            rready = r;
            tick;
            k++;
            if (r) i++;
        end
        rready = 1'b0;
        total++;
        if ({rvalid, rlast, arready} !== 3'b001)
            $display("FAIL %s burst_end got rv=%b rl=%b arr=%b required 0,0,1", name, rvalid, rlast, arready);
        else passed++;
    endtask

    task automatic test_single;
        run_burst("single", 32'h00000FFF, 0, 0, -1);
    endtask

    task automatic test_burst;
        run_burst("burst4", 32'h00000100, 3, 0, -1);
    endtask

    task automatic test_backpressure;
        run_burst("backpressure", 32'h00000100, 3, 2, -1);
    endtask

    task automatic test_wrap;
        run_burst("wrap", 32'hFFFFFFFC, 1, 0, -1);
    endtask

    task automatic test_random;
        for (int t = 0; t < 12; t++) begin
            run_burst("random", $urandom, int'($urandom_range(0, 15)), 1, -1);
        end
        run_burst("random_long", $urandom, 255, 1, -1);
    endtask

    task automatic test_reset_mid_burst;
        run_burst("reset_mid", 32'h00002000, 7, 0, 3);
        test_reset();
        run_burst("post_reset", 32'h00000000, 0, 0, -1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_wrap();
        test_random();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
